// File: rtl/health_bar_pkg.sv
// Shared colours, FSM state encoding and health clamping for the health-bar renderer.
package health_bar_pkg;

    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GHOST  = 16'hFA00;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t HOLD  = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t FILL  = 2'd3;

    function automatic logic [6:0] clamp_health(input logic [6:0] h, input logic [6:0] max_h);
        return (h > max_h) ? max_h : h;
    endfunction

endpackage

// File: rtl/health_width_calc.sv
// Maps health to target fill width and fill colour.
// Latency: combinational. Backpressure: none.
// Flow: always accepts; output follows input in the same cycle.
module health_width_calc
    import health_bar_pkg::*;
#(
    parameter int BAR_W      = 15,
    parameter int MAX_HEALTH = 100,
    parameter int LOW_THRESH = 20,
    parameter int MID_THRESH = 50
) (
    input  logic [6:0]  health_level,
    output logic [5:0]  tgt_w,
    output logic [15:0] fill_col
);

    logic [6:0]  health_c;
    logic [13:0] prod;

    always_comb begin
        health_c = clamp_health(health_level, 7'(MAX_HEALTH));
        prod     = 14'(health_c) * 14'(BAR_W);
        tgt_w    = 6'(prod / 14'(MAX_HEALTH));
        if (health_c <= 7'(LOW_THRESH)) begin
            fill_col = RED;
        end else if (health_c <= 7'(MID_THRESH)) begin
            fill_col = YELLOW;
        end else begin
            fill_col = GREEN;
        end
    end

endmodule

// File: rtl/health_bar_anim.sv
// Animated health bar with damage ghost; optional low-health blink under LOW_BLINK_EN.
// Latency: oled_data registered, 1 clk after X/Y; animation steps on frame_tick only.
// Backpressure: none; a pixel is produced every clock.
module health_bar_anim
    import health_bar_pkg::*;
#(
    parameter int BAR_W        = 15,
    parameter int BAR_H        = 2,
    parameter int MAX_HEALTH   = 100,
    parameter int LOW_THRESH   = 20,
    parameter int MID_THRESH   = 50,
    parameter int HOLD_FRAMES  = 4
`ifdef LOW_BLINK_EN
  , parameter int BLINK_FRAMES = 8
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [6:0]  health_level,
    input  logic [6:0]  X,
    input  logic [5:0]  Y,
    input  logic [6:0]  leftX,
    input  logic [5:0]  topY,
    input  logic [15:0] BACKGROUND,
    output logic [15:0] oled_data,
    output logic        busy
);

    logic [5:0]  tgt_w;
    logic [15:0] fill_col;

    health_width_calc #(
        .BAR_W      (BAR_W),
        .MAX_HEALTH (MAX_HEALTH),
        .LOW_THRESH (LOW_THRESH),
        .MID_THRESH (MID_THRESH)
    ) u_calc (
        .health_level (health_level),
        .tgt_w        (tgt_w),
        .fill_col     (fill_col)
    );

    state_t      state_q, state_d;
    logic [5:0]  fill_q, fill_d;
    logic [5:0]  ghost_q, ghost_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] oled_q, oled_d;
    logic [5:0]  fill_inc;
    logic        blink_on;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        ghost_d  = ghost_q;
        hold_d   = hold_q;
        fill_inc = fill_q + 6'd1;
        if (frame_tick) begin
            if (state_q == IDLE) begin
                if (tgt_w < fill_q) begin
                    ghost_d = fill_q;
                    fill_d  = tgt_w;
                    hold_d  = 8'd0;
                    state_d = HOLD;
                end else if (tgt_w > fill_q) begin
                    fill_d  = fill_inc;
                    ghost_d = fill_inc;
                    state_d = (fill_inc == tgt_w) ? IDLE : FILL;
                end
            end else if (tgt_w < fill_q) begin
                // New damage mid-animation keeps the widest ghost seen so far.
                ghost_d = (ghost_q > fill_q) ? ghost_q : fill_q;
                fill_d  = tgt_w;
                hold_d  = 8'd0;
                state_d = HOLD;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (tgt_w > fill_q) begin
                            ghost_d = fill_q;
                            state_d = FILL;
                        end else if (hold_q == 8'(HOLD_FRAMES - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                    DRAIN: begin
                        if (tgt_w > fill_q) begin
                            ghost_d = fill_q;
                            state_d = FILL;
                        end else if (ghost_q <= fill_inc) begin
                            ghost_d = fill_q;
                            state_d = IDLE;
                        end else begin
                            ghost_d = ghost_q - 6'd1;
                        end
                    end
                    default: begin
                        if (tgt_w == fill_q) begin
                            state_d = IDLE;
                        end else begin
                            fill_d  = fill_inc;
                            ghost_d = fill_inc;
                            if (fill_inc == tgt_w) begin
                                state_d = IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef LOW_BLINK_EN
    logic [6:0] health_c;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_on_q, blink_on_d;

    always_comb begin
        health_c    = clamp_health(health_level, 7'(MAX_HEALTH));
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (health_c > 7'(LOW_THRESH)) begin
            blink_cnt_d = 8'd0;
            blink_on_d  = 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = 8'd0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= 8'd0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_on = blink_on_q;
`else
    assign blink_on = 1'b1;
`endif

    logic [7:0] c, r, bw, bh, fw, gw;
    logic       in_rows, in_cols;

    // Offsets wrap modulo 256 so pixels left of / above the bar land far outside.
    always_comb begin
        c       = {1'b0, X} - {1'b0, leftX};
        r       = {2'b00, Y} - {2'b00, topY};
        bw      = 8'(BAR_W);
        bh      = 8'(BAR_H);
        fw      = {2'b00, fill_q};
        gw      = {2'b00, ghost_q};
        in_rows = (r >= 8'd1) && (r <= bh);
        in_cols = (c >= 8'd1) && (c <= bw);
        oled_d  = BACKGROUND;
        if (((r == 8'd0) || (r == bh + 8'd1)) && in_cols) begin
            oled_d = BLACK;
        end else if (in_rows && ((c == 8'd0) || (c == bw + 8'd1))) begin
            oled_d = BLACK;
        end else if (in_rows && in_cols) begin
            if (c <= fw) begin
                oled_d = blink_on ? fill_col : WHITE;
            end else if (c <= gw) begin
                oled_d = GHOST;
            end else begin
                oled_d = WHITE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fill_q  <= 6'd0;
            ghost_q <= 6'd0;
            hold_q  <= 8'd0;
            oled_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ghost_q <= ghost_d;
            hold_q  <= hold_d;
            oled_q  <= oled_d;
        end
    end

    assign oled_data = oled_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_health_bar_anim.sv
// Directed, table-driven bench for health_bar_anim at default parameters.
module tb_health_bar_anim;

    localparam logic [15:0] C_RED = 16'hF800;
    localparam logic [15:0] C_YEL = 16'hFFE0;
    localparam logic [15:0] C_GRN = 16'h07E0;
    localparam logic [15:0] C_BLK = 16'h0000;
    localparam logic [15:0] C_WHT = 16'hFFFF;
    localparam logic [15:0] C_GST = 16'hFA00;
    localparam logic [15:0] C_BG  = 16'h1234;
    localparam logic [6:0]  LX    = 7'd10;
    localparam logic [5:0]  TY    = 6'd20;

    logic        clk = 1'b0;
    logic        reset, frame_tick;
    logic [6:0]  health_level, X, leftX;
    logic [5:0]  Y, topY;
    logic [15:0] BACKGROUND, oled_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    health_bar_anim dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .health_level (health_level),
        .X            (X),
        .Y            (Y),
        .leftX        (leftX),
        .topY         (topY),
        .BACKGROUND   (BACKGROUND),
        .oled_data    (oled_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  x;
        logic [5:0]  y;
        logic [15:0] exp;
    } pix_vec_t;

    typedef struct {
        logic [6:0]  h;
        logic [5:0]  tgt;
        logic [15:0] col;
    } calc_vec_t;

    pix_vec_t  pv[14];
    calc_vec_t cv[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
        clk1();
        clk1();
        clk1();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic show(input int c, input int r);
        X = 7'(int'(LX) + c);
        Y = 6'(int'(TY) + r);
        clk1();
    endtask

    initial begin
        // Geometry with fill=6, ghost=15, health=40, bar at (10,20).
        pv[0]  = '{7'd13, 6'd21, C_YEL};
        pv[1]  = '{7'd20, 6'd21, C_GST};
        pv[2]  = '{7'd26, 6'd21, C_BLK};
        pv[3]  = '{7'd9,  6'd21, C_BG};
        pv[4]  = '{7'd10, 6'd20, C_BG};
        pv[5]  = '{7'd10, 6'd21, C_BLK};
        pv[6]  = '{7'd11, 6'd20, C_BLK};
        pv[7]  = '{7'd25, 6'd23, C_BLK};
        pv[8]  = '{7'd16, 6'd22, C_YEL};
        pv[9]  = '{7'd17, 6'd22, C_GST};
        pv[10] = '{7'd26, 6'd23, C_BG};
        pv[11] = '{7'd13, 6'd19, C_BG};
        pv[12] = '{7'd27, 6'd21, C_BG};
        pv[13] = '{7'd13, 6'd24, C_BG};

        cv[0] = '{7'd100, 6'd15, C_GRN};
        cv[1] = '{7'd50,  6'd7,  C_YEL};
        cv[2] = '{7'd40,  6'd6,  C_YEL};
        cv[3] = '{7'd20,  6'd3,  C_RED};
        cv[4] = '{7'd21,  6'd3,  C_YEL};
        cv[5] = '{7'd51,  6'd7,  C_GRN};
        cv[6] = '{7'd127, 6'd15, C_GRN};
        cv[7] = '{7'd0,   6'd0,  C_RED};
        cv[8] = '{7'd7,   6'd1,  C_RED};
        cv[9] = '{7'd6,   6'd0,  C_RED};

        reset = 1'b1; frame_tick = 1'b0; health_level = 7'd100;
        X = 7'd0; Y = 6'd0; leftX = LX; topY = TY; BACKGROUND = C_BG;
        clk1();
        clk1();
        check("rst_oled", oled_data, 16'h0000);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_fill", 16'(dut.fill_q), 16'd0);
        check("rst_ghost", 16'(dut.ghost_q), 16'd0);
        check("rst_state", 16'(dut.state_q), 16'd0);
        reset = 1'b0;

        // Fill from empty to full, one pixel per frame.
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("fill_up_%0d", i), 16'(dut.fill_q), 16'(i));
            if (i == 1) check("fill_busy", 16'(busy), 16'd1);
        end
        check("full_idle", 16'(busy), 16'd0);

        // Damage 100 -> 40: ghost held for 4 frames then drains.
        health_level = 7'd40;
        tick();
        check("dmg_fill", 16'(dut.fill_q), 16'd6);
        check("dmg_ghost", 16'(dut.ghost_q), 16'd15);
        check("dmg_busy", 16'(busy), 16'd1);

        for (int i = 0; i < 14; i++) begin
            X = pv[i].x;
            Y = pv[i].y;
            check($sformatf("pix_pre_%0d", i), 16'(oled_data === pv[i].exp && i > 0 && pv[i-1].exp != pv[i].exp), 16'd0);
            clk1();
            check($sformatf("pix_%0d", i), oled_data, pv[i].exp);
        end

        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("hold_%0d", i), 16'(dut.ghost_q), 16'd15);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("drain_%0d", k), 16'(dut.ghost_q), 16'(15 - k));
        end
        check("drain_idle", 16'(busy), 16'd0);
        show(10, 1);
        check("pix_white", oled_data, C_WHT);

        // Heal during DRAIN.
        health_level = 7'd100;
        ticks(9);
        check("refill", 16'(dut.fill_q), 16'd15);
        health_level = 7'd40;
        ticks(8);
        check("d12_ghost", 16'(dut.ghost_q), 16'd12);
        check("d12_state", 16'(dut.state_q), 16'd2);
        health_level = 7'd100;
        tick();
        check("heal_ghost", 16'(dut.ghost_q), 16'd6);
        check("heal_state", 16'(dut.state_q), 16'd3);
        ticks(9);
        check("heal_fill", 16'(dut.fill_q), 16'd15);
        check("heal_idle", 16'(busy), 16'd0);

        // Clamping and colour/width mapping.
        health_level = 7'd127;
        show(15, 1);
        check("pix_green", oled_data, C_GRN);
        for (int i = 0; i < 10; i++) begin
            health_level = cv[i].h;
            #1;
            check($sformatf("tgt_%0d", cv[i].h), 16'(dut.tgt_w), 16'(cv[i].tgt));
            check($sformatf("col_%0d", cv[i].h), dut.fill_col, cv[i].col);
        end

        health_level = 7'd0;
        tick();
        check("zero_fill", 16'(dut.fill_q), 16'd0);
        show(1, 1);
        check("zero_ghost_pix", oled_data, C_GST);
        ticks(5);
        check("mid_drain_state", 16'(dut.state_q), 16'd2);
        check("mid_drain_ghost", 16'(dut.ghost_q), 16'd14);

        // Reset mid-DRAIN without frame_tick.
        reset = 1'b1;
        clk1();
        check("rst2_fill", 16'(dut.fill_q), 16'd0);
        check("rst2_ghost", 16'(dut.ghost_q), 16'd0);
        check("rst2_state", 16'(dut.state_q), 16'd0);
        check("rst2_oled", oled_data, 16'h0000);
        check("rst2_busy", 16'(busy), 16'd0);

        // Low health fill: blinks with LOW_BLINK_EN, solid otherwise.
        health_level = 7'd15;
        X = LX + 7'd1;
        Y = TY + 6'd1;
        clk1();
        reset = 1'b0;
        ticks(2);
        check("low_fill", 16'(dut.fill_q), 16'd2);
        check("low_red", oled_data, C_RED);
        ticks(6);
`ifdef LOW_BLINK_EN
        check("blink_off", oled_data, C_WHT);
`else
        check("solid_8", oled_data, C_RED);
`endif
        ticks(8);
        check("blink_on_16", oled_data, C_RED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
